vram_responder: RTL
===================

VRAM_RESPONDER -- requirements
Module: vram_responder

Interface
REQ-001 SHALL have port: clk_pix  input  1  single clock for the entire block, rising-edge.
REQ-002 SHALL have port: nreset  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: vram_address  input  13  video fetch address from the display generator.
REQ-004 SHALL have port: vram_data  output  8  registered video read data.
REQ-005 SHALL have port: cpu_req  input  1  CPU access request, level, held until cpu_ack.
REQ-006 SHALL have port: cpu_we  input  1  1=write, 0=read; sampled with cpu_req.
REQ-007 SHALL have port: cpu_addr  input  13  CPU byte address.
REQ-008 SHALL have port: cpu_wdata  input  8  CPU write data.
REQ-009 SHALL have port: cpu_rdata  output  8  CPU read data; valid while cpu_ack=1.
REQ-010 SHALL have port: cpu_ack  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL hold an 8192x8 single-port synchronous RAM with one read or write per clock.
REQ-012 SHALL flag a video access pending in any cycle where vram_address differs from the last serviced video address, or no video address has been serviced since reset.
REQ-013 SHALL give a pending video access the RAM in that same cycle, with absolute priority over the CPU.
REQ-014 SHALL update vram_data on the edge ending the pending cycle, so data is stable by the 2nd rising edge after vram_address changes.
REQ-015 SHALL hold vram_data unchanged between video accesses, whatever the CPU does.
REQ-016 SHALL implement a CPU FSM with states IDLE and ACK.
REQ-017 In IDLE with cpu_req=1 and no video pending, SHALL perform the CPU RAM operation on that edge and go to ACK.
REQ-018 In IDLE with a video access pending, SHALL stay in IDLE (CPU waits).
REQ-019 In ACK, SHALL assert cpu_ack=1 with cpu_rdata valid (reads), leave the RAM free for video, and return to IDLE next edge.
REQ-020 SHALL keep cpu_rdata stable after ACK until the next CPU read completes; writes leave cpu_rdata unchanged.
REQ-021 SHALL bound CPU latency from cpu_req rise to cpu_ack at 3 cycles, given video address changes no closer than 2 cycles apart.
REQ-022 If cpu_req is still high in the IDLE cycle after ACK, SHALL treat it as a new request.
REQ-023 On a video read and CPU write to the same address in the same cycle, SHALL return the old byte to video (video first), then commit the write.
REQ-024 SHALL produce no X or glitch on cpu_ack; it is driven from a register.

Reset
REQ-025 On nreset=0, SHALL set vram_data=8'h00, cpu_rdata=8'h00, cpu_ack=0, FSM=IDLE, and clear the serviced-video-address valid flag.
REQ-026 SHALL NOT initialise RAM contents on reset.
REQ-027 On reset during ACK, SHALL drop the ack; a write already committed on an earlier edge remains in RAM.
REQ-028 SHALL deassert reset cleanly; the first video access after reset is serviced even if vram_address=0.

Configuration
REQ-029 With macro VRAM_RANGE_CHECK_EN defined, SHALL treat CPU addresses >=6912: reads return 8'hFF, writes are discarded but still acked with normal timing.
REQ-029a With VRAM_RANGE_CHECK_EN defined, video reads SHALL NOT be range-checked.
REQ-030 With VRAM_RANGE_CHECK_EN undefined, SHALL make all 8192 bytes CPU-accessible.

Structure
REQ-031 SHALL define in package vram_pkg: VRAM_AW=13, VRAM_DW=8, SCREEN_BYTES=6912, ATTR_BASE=6144, and the CPU FSM state enum.
REQ-032 SHALL place the RAM array in sub-module vram_store (clk_pix, addr, we, wdata, rdata, 1-cycle read latency, no reset).

Verification
REQ-033 SHALL verify CPU write 8'hA5 to 13'h0000, then change vram_address to 0 -> vram_data=8'hA5 on 2nd edge after the change.
REQ-034 SHALL verify CPU read request in the same cycle vram_address changes -> video served first; cpu_ack exactly 3 cycles after cpu_req rise.
REQ-035 SHALL verify vram_address=13'h1800 unchanged for 100 cycles with back-to-back CPU writes -> vram_data constant, one cpu_ack per request.
REQ-036 SHALL verify with VRAM_RANGE_CHECK_EN: write 8'h3C to 13'h1B00, read back -> cpu_rdata=8'hFF; undefined -> 8'h3C.
REQ-037 SHALL verify nreset pulsed while in ACK -> cpu_ack=0, vram_data=8'h00 immediately; the first video address after release (including 0) is serviced.
REQ-038 SHALL verify same-address video read and CPU write (old 8'h11, new 8'h22) -> vram_data=8'h11; a later CPU read returns 8'h22.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared sizes, screen-layout constants and the CPU port FSM state for the video RAM responder.
package vram_pkg;

    localparam int VRAM_AW      = 13;
    localparam int VRAM_DW      = 8;
    localparam int SCREEN_BYTES = 6912;
    localparam int ATTR_BASE    = 6144;

    typedef enum logic {
        CPU_IDLE = 1'b0,
        CPU_ACK  = 1'b1
    } cpu_state_e;

    // True when a CPU address falls inside the displayed bitmap + attribute area.
    function automatic logic cpu_addr_in_screen(input logic [VRAM_AW-1:0] addr);
        return addr < VRAM_AW'(SCREEN_BYTES);
    endfunction

endpackage

// File: rtl/vram_responder_if.sv
// Video fetch and CPU access bus between the display generator / CPU side (master) and the responder (slave).
interface vram_responder_if
    import vram_pkg::*;
();

    // CPU handshake: cpu_req is a level held with cpu_we/cpu_addr/cpu_wdata stable until
    // a one-cycle cpu_ack; a read's cpu_rdata is valid while cpu_ack=1 and held afterwards.
    logic [VRAM_AW-1:0] vram_address;
    logic [VRAM_DW-1:0] vram_data;
    logic               cpu_req;
    logic               cpu_we;
    logic [VRAM_AW-1:0] cpu_addr;
    logic [VRAM_DW-1:0] cpu_wdata;
    logic [VRAM_DW-1:0] cpu_rdata;
    logic               cpu_ack;
    cpu_state_e         dbg_state;

    modport master (
        output vram_address, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vram_data, cpu_rdata, cpu_ack, dbg_state
    );

    modport slave (
        input  vram_address, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vram_data, cpu_rdata, cpu_ack, dbg_state
    );

endinterface

// File: rtl/vram_store.sv
// 8192x8 single-port synchronous RAM: one read or write per clock, read data one cycle later, no reset.
module vram_store
    import vram_pkg::*;
(
    input  logic               clk_pix,
    input  logic [VRAM_AW-1:0] addr,
    input  logic               we,
    input  logic [VRAM_DW-1:0] wdata,
    output logic [VRAM_DW-1:0] rdata
);

    logic [VRAM_DW-1:0] r_mem [0:(1<<VRAM_AW)-1];
    logic [VRAM_DW-1:0] r_rdata;

    // Read-before-write: a write cycle returns the byte that was there before.
    always_ff @(posedge clk_pix) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/vram_responder.sv
// Arbitrates one video RAM between display fetches (absolute priority) and a CPU req/ack port.
// Optional build macro VRAM_RANGE_CHECK_EN: CPU addresses >= SCREEN_BYTES read 8'hFF and drop writes.
module vram_responder
    import vram_pkg::*;
(
    input  logic              clk_pix,
    input  logic              nreset,
    vram_responder_if.slave   bus
);

    cpu_state_e         r_state;
    cpu_state_e         w_state_nxt;
    logic               r_vid_valid;
    logic [VRAM_AW-1:0] r_vid_addr;
    logic               r_vid_rd;
    logic [VRAM_DW-1:0] r_vram_data;
    logic [VRAM_DW-1:0] r_cpu_rdata;
    logic               r_ack;
    logic               r_ack_rd;
    logic               r_ack_oor;

    logic               w_vid_pend;
    logic               w_in_range;
    logic               w_cpu_go;
    logic [VRAM_AW-1:0] w_ram_addr;
    logic               w_ram_we;
    logic [VRAM_DW-1:0] w_ram_wdata;
    logic [VRAM_DW-1:0] w_ram_rdata;
    logic [VRAM_DW-1:0] w_cpu_rd_val;

    assign w_vid_pend = !r_vid_valid || (bus.vram_address != r_vid_addr);

`ifdef VRAM_RANGE_CHECK_EN
    assign w_in_range = cpu_addr_in_screen(bus.cpu_addr);
`else
    assign w_in_range = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cpu_go    = 1'b0;
        w_ram_addr  = bus.vram_address;
        w_ram_we    = 1'b0;
        w_ram_wdata = bus.cpu_wdata;
        case (r_state)
            CPU_IDLE: begin
                if (bus.cpu_req && !w_vid_pend) begin
                    w_cpu_go    = 1'b1;
                    w_ram_addr  = bus.cpu_addr;
                    w_ram_we    = bus.cpu_we && w_in_range;
                    w_state_nxt = CPU_ACK;
                end
            end
            CPU_ACK: begin
                w_state_nxt = CPU_IDLE;
            end
            default: begin
                w_state_nxt = CPU_IDLE;
            end
        endcase
    end

    vram_store u_store (
        .clk_pix (clk_pix),
        .addr    (w_ram_addr),
        .we      (w_ram_we),
        .wdata   (w_ram_wdata),
        .rdata   (w_ram_rdata)
    );

    always_ff @(posedge clk_pix or negedge nreset) begin
        if (!nreset) begin
            r_state     <= CPU_IDLE;
            r_vid_valid <= 1'b0;
            r_vid_addr  <= '0;
            r_vid_rd    <= 1'b0;
            r_vram_data <= '0;
            r_cpu_rdata <= '0;
            r_ack       <= 1'b0;
            r_ack_rd    <= 1'b0;
            r_ack_oor   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_vid_rd <= w_vid_pend;
            if (w_vid_pend) begin
                r_vid_valid <= 1'b1;
                r_vid_addr  <= bus.vram_address;
            end
            // RAM output belongs to video only in the cycle after a video fetch.
            if (r_vid_rd) begin
                r_vram_data <= w_ram_rdata;
            end
            r_ack <= w_cpu_go;
            if (w_cpu_go) begin
                r_ack_rd  <= !bus.cpu_we;
                r_ack_oor <= !w_in_range;
            end
            if (r_ack && r_ack_rd) begin
                r_cpu_rdata <= w_cpu_rd_val;
            end
        end
    end

    assign w_cpu_rd_val  = r_ack_oor ? 8'hFF : w_ram_rdata;
    assign bus.cpu_rdata = (r_ack && r_ack_rd) ? w_cpu_rd_val : r_cpu_rdata;
    assign bus.cpu_ack   = r_ack;
    assign bus.vram_data = r_vram_data;
    assign bus.dbg_state = r_state;

endmodule
